// File: rtl/ring_dco_pkg.sv
// Shared types and elaboration helpers for the ring DCO.
// Holds the controller state encoding and the reachable-tap computation.
package ring_dco_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    SLEW  = 2'd3
  } dco_state_t;

  // Highest usable tap: bounded by the select width and by the ring length.
  function automatic int sel_max_f(input int coarse_width, input int inverternum);
    int by_width;
    int by_ring;
    by_width = (1 << coarse_width) - 1;
    by_ring  = (inverternum - 1) / 2;
    return (by_width < by_ring) ? by_width : by_ring;
  endfunction

endpackage

// File: rtl/ring_osc_core.sv
// Purpose: NAND-gated inverter ring with a tap mux that shortens the loop by two stages per tap.
// Latency: combinational; a tap change reaches the loop one mux delay after tap_sel settles.
// Backpressure: none; free-running whenever ring_en is high, static when low.
module ring_osc_core
  import ring_dco_pkg::*;
#(
  parameter int RINGSIZE     = 421,
  parameter int COARSE_WIDTH = 5,
  parameter int EARLY_OFFSET = 70
) (
  input  logic                    ring_en,
  input  logic [COARSE_WIDTH-1:0] tap_sel,
  output logic                    clk_o,
  output logic                    early_clk_o
);

  localparam int INVERTERNUM = RINGSIZE - 1;
  localparam int SEL_MAX     = sel_max_f(COARSE_WIDTH, INVERTERNUM);
  localparam int NUM_TAPS    = 1 << COARSE_WIDTH;

  if ((RINGSIZE % 2) == 0) begin : g_chk_odd
    $error("ring_osc_core: RINGSIZE must be odd");
  end
  if (EARLY_OFFSET < 2 * SEL_MAX + 2 || EARLY_OFFSET > INVERTERNUM) begin : g_chk_early
    $error("ring_osc_core: EARLY_OFFSET out of range");
  end

  (* dont_touch = "true" *) logic [INVERTERNUM:0] stage;
  logic [NUM_TAPS-1:0] taps;
  logic                feedback;
  logic                nand_in;

  always_comb begin
    stage[0] = ~(ring_en & nand_in);
    for (int i = 1; i <= INVERTERNUM; i++) begin
      stage[i] = ~stage[i-1];
    end
  end

  // Taps beyond the reachable range clamp to the fastest legal loop.
  for (genvar n = 0; n < NUM_TAPS; n++) begin : g_tap
    if (n <= SEL_MAX) begin : g_live
      assign taps[n] = stage[INVERTERNUM - 2*n];
    end else begin : g_clamp
      assign taps[n] = stage[INVERTERNUM - 2*SEL_MAX];
    end
  end

  assign feedback = taps[tap_sel];

`ifdef SYNTHESIS
  assign nand_in = feedback;
`else
  // A zero-delay model cannot settle a free-running loop, so it is opened at the NAND here.
  logic unused_feedback;
  assign nand_in         = 1'b1;
  assign unused_feedback = feedback;
`endif

  assign clk_o       = stage[INVERTERNUM];
  assign early_clk_o = stage[INVERTERNUM - EARLY_OFFSET];

endmodule

// File: rtl/ring_dco.sv
// Purpose: ADPLL ring DCO controller (start-up, word handshake, one-tap-per-cycle slew); RING_DCO_DITHER_EN adds frac dither.
// Latency: running SETTLE_CYCLES after enable; accepted word of distance d reaches tap_sel_o over d cycles.
// Backpressure: ctrl_ready_o low in OFF/START/SLEW; words offered while low are dropped, not queued.
module ring_dco
  import ring_dco_pkg::*;
#(
  parameter int RINGSIZE      = 421,
  parameter int COARSE_WIDTH  = 5,
  parameter int FRAC_WIDTH    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int EARLY_OFFSET  = 70
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic [COARSE_WIDTH+FRAC_WIDTH-1:0] ctrl_word_i,
  input  logic                               ctrl_valid_i,
  output logic                               ctrl_ready_o,
  output logic [COARSE_WIDTH-1:0]            tap_sel_o,
  output logic                               running_o,
  output logic                               early_clk_o,
  output logic                               clk_o
);

  localparam int INVERTERNUM = RINGSIZE - 1;
  localparam int SEL_MAX     = sel_max_f(COARSE_WIDTH, INVERTERNUM);
  localparam int CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [COARSE_WIDTH-1:0] SEL_MAX_C = COARSE_WIDTH'(SEL_MAX);
  localparam logic [COARSE_WIDTH:0]   SEL_MAX_W = (COARSE_WIDTH+1)'(SEL_MAX);

  if (SETTLE_CYCLES < 1) begin : g_chk_settle
    $error("ring_dco: SETTLE_CYCLES must be at least 1");
  end

  dco_state_t              state_q, state_d;
  logic [COARSE_WIDTH-1:0] cur_q, cur_d, target_q, target_d, tap_q, tap_d;
  logic [COARSE_WIDTH-1:0] cur_step, word_coarse, word_target;
  logic [COARSE_WIDTH:0]   eff_tap;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ready_q, ready_d, running_q, running_d;
  logic                    capture, carry, ring_en;

  assign word_coarse = ctrl_word_i[COARSE_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
  assign word_target = (word_coarse > SEL_MAX_C) ? SEL_MAX_C : word_coarse;
  assign capture     = (state_q == RUN) && ctrl_valid_i && ready_q;
  assign cur_step    = (target_q > cur_q) ? cur_q + 1'b1 : cur_q - 1'b1;

`ifdef RING_DCO_DITHER_EN
  logic [FRAC_WIDTH-1:0] frac_q, frac_d, acc_q, acc_d, frac_use;
  logic [FRAC_WIDTH:0]   acc_sum;
  logic                  dither_on;

  // A newly captured frac already drives the accumulator on its capture edge.
  assign dither_on = enable_i && (state_q == RUN || state_q == SLEW);
  assign frac_use  = capture ? ctrl_word_i[FRAC_WIDTH-1:0] : frac_q;
  assign acc_sum   = {1'b0, acc_q} + {1'b0, frac_use};

  always_comb begin
    frac_d = '0;
    acc_d  = '0;
    carry  = 1'b0;
    if (dither_on) begin
      frac_d = frac_use;
      acc_d  = acc_sum[FRAC_WIDTH-1:0];
      carry  = acc_sum[FRAC_WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frac_q <= '0;
      acc_q  <= '0;
    end else begin
      frac_q <= frac_d;
      acc_q  <= acc_d;
    end
  end
`else
  logic unused_frac;
  assign carry       = 1'b0;
  assign unused_frac = ^ctrl_word_i[FRAC_WIDTH-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    running_d = running_q;
    case (state_q)
      OFF: begin
        if (enable_i) begin
          state_d = START;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d   = RUN;
          ready_d   = 1'b1;
          running_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        if (capture) begin
          target_d = word_target;
          if (word_target != cur_q) begin
            state_d = SLEW;
            ready_d = 1'b0;
          end
        end
      end
      SLEW: begin
        cur_d = cur_step;
        if (cur_step == target_q) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      default: state_d = OFF;
    endcase

    // Disable wins over everything above, including a capture on this edge.
    if (!enable_i) begin
      state_d   = OFF;
      cur_d     = '0;
      target_d  = '0;
      cnt_d     = '0;
      ready_d   = 1'b0;
      running_d = 1'b0;
    end

    eff_tap = {1'b0, cur_d} + {{COARSE_WIDTH{1'b0}}, carry};
    tap_d   = (eff_tap > SEL_MAX_W) ? SEL_MAX_C : eff_tap[COARSE_WIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= OFF;
      cur_q     <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      running_q <= 1'b0;
      tap_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      running_q <= running_d;
      tap_q     <= tap_d;
    end
  end

  assign ring_en      = (state_q != OFF);
  assign ctrl_ready_o = ready_q;
  assign running_o    = running_q;
  assign tap_sel_o    = tap_q;

  ring_osc_core #(
    .RINGSIZE     (RINGSIZE),
    .COARSE_WIDTH (COARSE_WIDTH),
    .EARLY_OFFSET (EARLY_OFFSET)
  ) u_core (
    .ring_en     (ring_en),
    .tap_sel     (tap_q),
    .clk_o       (clk_o),
    .early_clk_o (early_clk_o)
  );

endmodule

// File: tb/tb_ring_dco.sv
// Scoreboard bench for ring_dco: a cycle model predicts tap/ready/running per edge, a monitor compares.
// Built with a short ring (SEL_MAX = 20) so coarse words above 20 exercise saturation.
module tb_ring_dco;

  localparam int RINGSIZE    = 43;
  localparam int CW          = 5;
  localparam int FW          = 4;
  localparam int SETTLE      = 16;
  localparam int EARLY_OFF   = 42;
  localparam int INVERTERNUM = RINGSIZE - 1;
  localparam int SEL_MAX     = 20;

  typedef struct {
    int  tap;
    bit  rdy;
    bit  run;
    int  cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          enable_i = 1'b0;
  logic [CW+FW-1:0] ctrl_word_i = '0;
  logic          ctrl_valid_i = 1'b0;
  logic          ctrl_ready_o;
  logic [CW-1:0] tap_sel_o;
  logic          running_o;
  logic          ring_early;
  logic          ring_clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  // Model state: phase 0 = off, 1 = settling, 2 = running.
  int m_phase = 0, m_left = 0, m_cur = 0, m_tgt = 0, m_frac = 0, m_acc = 0;

  always #5 clk = ~clk;

  ring_dco #(
    .RINGSIZE      (RINGSIZE),
    .COARSE_WIDTH  (CW),
    .FRAC_WIDTH    (FW),
    .SETTLE_CYCLES (SETTLE),
    .EARLY_OFFSET  (EARLY_OFF)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .ctrl_word_i  (ctrl_word_i),
    .ctrl_valid_i (ctrl_valid_i),
    .ctrl_ready_o (ctrl_ready_o),
    .tap_sel_o    (tap_sel_o),
    .running_o    (running_o),
    .early_clk_o  (ring_early),
    .clk_o        (ring_clk)
  );

  task automatic model_edge(input bit rst, input bit en, input bit vld,
                            input logic [CW+FW-1:0] word, output bit taken);
    int   carry;
    int   coarse;
    exp_t e;
    taken = 1'b0;
    carry = 0;
    if (rst || !en) begin
      m_phase = 0; m_left = 0; m_cur = 0; m_tgt = 0; m_frac = 0; m_acc = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
      m_left  = SETTLE;
    end else if (m_phase == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) m_phase = 2;
    end else begin
      if (m_cur != m_tgt) begin
        m_cur = (m_tgt > m_cur) ? m_cur + 1 : m_cur - 1;
      end else if (vld) begin
        taken  = 1'b1;
        coarse = int'(word[CW+FW-1:FW]);
        m_tgt  = (coarse > SEL_MAX) ? SEL_MAX : coarse;
        m_frac = int'(word[FW-1:0]);
      end
`ifdef RING_DCO_DITHER_EN
      m_acc = m_acc + m_frac;
      carry = m_acc / (1 << FW);
      m_acc = m_acc % (1 << FW);
`endif
    end
    e.tap = (m_cur + carry > SEL_MAX) ? SEL_MAX : m_cur + carry;
    e.run = (m_phase == 2);
    e.rdy = (m_phase == 2) && (m_cur == m_tgt);
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit en, input bit vld,
                       input logic [CW+FW-1:0] word, output bit taken);
    @(negedge clk);
    cyc          = cyc + 1;
    reset_i      = rst;
    enable_i     = en;
    ctrl_valid_i = vld;
    ctrl_word_i  = word;
    model_edge(rst, en, vld, word, taken);
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, '0, t);
  endtask

  task automatic send(input int c, input int f);
    bit t;
    t = 1'b0;
    for (int i = 0; i < 200 && !t; i++) drive(1'b0, 1'b1, 1'b1, {CW'(c), FW'(f)}, t);
    if (!t) begin
      errors++;
      $display("FAIL send: coarse %0d frac %0d not accepted within 200 cycles", c, f);
    end
    drive(1'b0, 1'b1, 1'b0, '0, t);
    if (t) begin
      errors++;
      $display("FAIL send: unexpected second accept of coarse %0d", c);
    end
  endtask

  // Monitor: one prediction per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (int'(tap_sel_o) != e.tap) begin
          errors++;
          $display("FAIL tap cyc %0d: got %0d expected %0d", e.cyc, tap_sel_o, e.tap);
        end
        checks++;
        if (ctrl_ready_o !== e.rdy) begin
          errors++;
          $display("FAIL ready cyc %0d: got %b expected %b", e.cyc, ctrl_ready_o, e.rdy);
        end
        checks++;
        if (running_o !== e.run) begin
          errors++;
          $display("FAIL running cyc %0d: got %b expected %b", e.cyc, running_o, e.run);
        end
      end
    end
  end

  initial begin
    bit t;
    bit en_state;
    bit idle_lvl;

    // Reset with enable already high; controller must stay off until release.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, '0, t);
    @(posedge clk);
    #2;
    idle_lvl = ((INVERTERNUM % 2) == 0);
    checks++;
    if (ring_clk !== idle_lvl || ring_early !== idle_lvl) begin
      errors++;
      $display("FAIL ring_idle: clk_o %b early_clk_o %b expected %b", ring_clk, ring_early, idle_lvl);
    end

    // Start-up and the first slew, with a rival word offered mid-slew.
    idle(20);
    send(5, 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, {5'd9, 4'd0}, t);
    idle(4);

    // Saturation at the ring limit, then a same-target word.
    send(31, 0);
    idle(22);
    send(20, 0);
    idle(3);

    // Fractional dither patterns.
    send(3, 8);
    idle(24);
    send(3, 4);
    idle(12);

    // Disable mid-slew at tap 2 heading to 7, then a full restart.
    send(0, 0);
    idle(6);
    send(7, 0);
    idle(1);
    drive(1'b0, 1'b0, 1'b0, '0, t);
    drive(1'b0, 1'b0, 1'b1, {5'd4, 4'd0}, t);
    idle(20);
    send(12, 15);
    idle(14);

    // Randomised traffic with sporadic disable and reset.
    en_state = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if (en_state && $urandom_range(0, 99) < 1) en_state = 1'b0;
      else if (!en_state && $urandom_range(0, 99) < 15) en_state = 1'b1;
      drive(($urandom_range(0, 199) == 0), en_state, ($urandom_range(0, 99) < 35),
            (CW+FW)'($urandom), t);
    end
    idle(3);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
